mem_port_arbiter: RTL

- Shares the single byte-addressable memory between two requesters: port 0 is the CPU FSM and port 1 is the program loader/debug port.
- Serialises accesses and sequences the memory's fixed read latency and its done/error write handshake.
- Returns read data or error to the granted port with a one-cycle ack pulse.
- Sits between the core/loader and the memory instance; drives the memory's address, write_mode and write-data inputs.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared byte-addressable memory: round-robin grant,
// fixed-latency read sequencing and done/error/timeout write handshake.
module mem_port_arbiter #(
  parameter int READ_LAT = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_wsize,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_wsize,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_write_mode,
  output logic [7:0]  mem_write_byte,
  output logic [15:0] mem_write_half_word,
  output logic [31:0] mem_write_word,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic [31:0] mem_word_output,
  output logic        busy,
  output logic        grant_id
);
  localparam int CNT_MAX = (TIMEOUT > READ_LAT) ? TIMEOUT : READ_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS_RD, ACCESS_WR, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          grant_id_q, grant_id_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          pick;
  logic          finish;
  logic          finish_err;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    ack_d        = ack_q;
    err_d        = err_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    pick         = 1'b0;
    finish       = 1'b0;
    finish_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Under contention the port that did not win last time goes first.
          pick         = (m0_req && m1_req) ? ~last_grant_q : m1_req;
          grant_id_d   = pick;
          last_grant_d = pick;
          addr_d       = pick ? m1_addr  : m0_addr;
          wdata_d      = pick ? m1_wdata : m0_wdata;
          mode_d       = pick ? m1_wsize : m0_wsize;
          cnt_d        = '0;
          state_d      = (mode_d == 2'd0) ? ACCESS_RD : ACCESS_WR;
        end
      end
      ACCESS_RD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(READ_LAT - 1)) begin
          if (grant_id_q) m1_rdata_d = mem_word_output;
          else            m0_rdata_d = mem_word_output;
          finish     = 1'b1;
          finish_err = mem_error;
        end
      end
      ACCESS_WR: begin
        if (mem_error) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else if (mem_done) begin
          finish = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          finish     = 1'b1;
          finish_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        ack_d   = 2'b00;
        err_d   = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Entering RESP: write strobe drops on this edge and the ack/err pulse starts.
    if (finish) begin
      state_d = RESP;
      mode_d  = 2'd0;
      ack_d   = grant_id_q ? 2'b10 : 2'b01;
      err_d   = finish_err ? ack_d : 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mode_q       <= 2'd0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign mem_address         = addr_q;
  assign mem_write_mode      = mode_q;
  assign mem_write_byte      = wdata_q[7:0];
  assign mem_write_half_word = wdata_q[15:0];
  assign mem_write_word      = wdata_q;
  assign m0_ack              = ack_q[0];
  assign m1_ack              = ack_q[1];
  assign m0_err              = err_q[0];
  assign m1_err              = err_q[1];
  assign m0_rdata            = m0_rdata_q;
  assign m1_rdata            = m1_rdata_q;
  assign busy                = (state_q != IDLE);
  assign grant_id            = grant_id_q;

endmodule
